// File: rtl/idct_pkg.sv
// Shared fixed-point constants for the NanoJPEG integer IDCT (row and column passes).
package idct_pkg;

  localparam int W1 = 2841;
  localparam int W2 = 2676;
  localparam int W3 = 2408;
  localparam int W5 = 1609;
  localparam int W6 = 1108;
  localparam int W7 = 565;

  localparam int C181   = 181;
  localparam int ROUND  = 128;
  localparam int SH_PRE = 11;
  localparam int SH_OUT = 8;
  localparam int SH_DC  = 3;

  // Stage counter values; ST_S1 doubles as the DC-shortcut output step.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_S5   = 3'd5
  } stage_e;

endpackage

// File: rtl/row_idct_rot.sv
// Rotation pair: registers s = K*(a+b), then o_a = s + CA*a and o_b = s + CB*b.
import idct_pkg::*;

module row_idct_rot #(
  parameter int K  = W7,
  parameter int CA = W1 - W7,
  parameter int CB = -(W1 + W7)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ld_sum,
  input  logic               i_ld_out,
  input  logic signed [31:0] i_a,
  input  logic signed [31:0] i_b,
  output logic signed [31:0] o_a,
  output logic signed [31:0] o_b
);

  logic signed [31:0] r_sum;
  logic signed [31:0] r_a;
  logic signed [31:0] r_b;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sum <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else begin
      if (i_ld_sum) r_sum <= K * (i_a + i_b);
      if (i_ld_out) begin
        r_a <= r_sum + CA * i_a;
        r_b <= r_sum + CB * i_b;
      end
    end
  end

  assign o_a = r_a;
  assign o_b = r_b;

endmodule

// File: rtl/row_idct.sv
// One-shot 8-point row IDCT, bit-exact to NanoJPEG; result held with rdy until reset.
import idct_pkg::*;

module row_idct (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] x0,
  input  logic signed [31:0] x1,
  input  logic signed [31:0] x2,
  input  logic signed [31:0] x3,
  input  logic signed [31:0] x4,
  input  logic signed [31:0] x5,
  input  logic signed [31:0] x6,
  input  logic signed [31:0] x7,
  output logic signed [31:0] y0,
  output logic signed [31:0] y1,
  output logic signed [31:0] y2,
  output logic signed [31:0] y3,
  output logic signed [31:0] y4,
  output logic signed [31:0] y5,
  output logic signed [31:0] y6,
  output logic signed [31:0] y7,
  output logic               rdy
);

  stage_e             ctr;
  stage_e             w_ctr_nxt;
  logic               flag;
  logic               w_capture, w_ld1, w_ld2, w_ld3, w_ld4, w_dc_out, w_full_out;

  logic signed [31:0] r_x [8];
  logic signed [31:0] r_y [8];
  logic signed [31:0] r_a0, r_a1, r_b8, r_b0;
  logic signed [31:0] r_c0, r_c1, r_c3, r_c4, r_c5, r_c6, r_c7, r_c8;
  logic signed [31:0] r_d2, r_d4;
  logic signed [31:0] w_b2, w_b3, w_b4, w_b5, w_b6, w_b7;

  always_ff @(posedge clk) begin
    if (!reset) ctr <= ST_IDLE;
    else        ctr <= w_ctr_nxt;
  end

  // Once rdy is set the counter parks (S1 for DC, S5 for full path) and nothing loads.
  always_comb begin
    w_ctr_nxt  = ctr;
    w_capture  = 1'b0;
    w_ld1      = 1'b0;
    w_ld2      = 1'b0;
    w_ld3      = 1'b0;
    w_ld4      = 1'b0;
    w_dc_out   = 1'b0;
    w_full_out = 1'b0;
    case (ctr)
      ST_IDLE: if (!rdy) begin w_capture = 1'b1; w_ctr_nxt = ST_S1; end
      ST_S1: begin
        if (!rdy && flag) w_dc_out = 1'b1;
        else if (!rdy) begin w_ld1 = 1'b1; w_ctr_nxt = ST_S2; end
      end
      ST_S2:   begin w_ld2 = 1'b1; w_ctr_nxt = ST_S3; end
      ST_S3:   begin w_ld3 = 1'b1; w_ctr_nxt = ST_S4; end
      ST_S4:   begin w_ld4 = 1'b1; w_ctr_nxt = ST_S5; end
      ST_S5:   if (!rdy) w_full_out = 1'b1;
      default: w_ctr_nxt = ST_IDLE;
    endcase
  end

  row_idct_rot #(.K(W7), .CA(W1 - W7),    .CB(-(W1 + W7))) u_rot_17 (
    .i_clk(clk), .i_rst_n(reset), .i_ld_sum(w_ld1), .i_ld_out(w_ld2),
    .i_a(r_x[1]), .i_b(r_x[7]), .o_a(w_b4), .o_b(w_b5));

  row_idct_rot #(.K(W3), .CA(-(W3 - W5)), .CB(-(W3 + W5))) u_rot_53 (
    .i_clk(clk), .i_rst_n(reset), .i_ld_sum(w_ld1), .i_ld_out(w_ld2),
    .i_a(r_x[5]), .i_b(r_x[3]), .o_a(w_b6), .o_b(w_b7));

  row_idct_rot #(.K(W6), .CA(W2 - W6),    .CB(-(W2 + W6))) u_rot_26 (
    .i_clk(clk), .i_rst_n(reset), .i_ld_sum(w_ld1), .i_ld_out(w_ld2),
    .i_a(r_x[2]), .i_b(r_x[6]), .o_a(w_b3), .o_b(w_b2));

  always_ff @(posedge clk) begin
    if (!reset) begin
      flag <= 1'b0;
      rdy  <= 1'b0;
      r_a0 <= '0; r_a1 <= '0; r_b8 <= '0; r_b0 <= '0;
      r_c0 <= '0; r_c1 <= '0; r_c3 <= '0; r_c4 <= '0;
      r_c5 <= '0; r_c6 <= '0; r_c7 <= '0; r_c8 <= '0;
      r_d2 <= '0; r_d4 <= '0;
      for (int i = 0; i < 8; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      if (w_capture) begin
        r_x[0] <= x0; r_x[1] <= x1; r_x[2] <= x2; r_x[3] <= x3;
        r_x[4] <= x4; r_x[5] <= x5; r_x[6] <= x6; r_x[7] <= x7;
        flag   <= ((x1 | x2 | x3 | x4 | x5 | x6 | x7) == '0);
      end
      if (w_ld1) begin
        r_a0 <= (r_x[0] <<< SH_PRE) + ROUND;
        r_a1 <= r_x[4] <<< SH_PRE;
      end
      if (w_ld2) begin
        r_b8 <= r_a0 + r_a1;
        r_b0 <= r_a0 - r_a1;
      end
      if (w_ld3) begin
        r_c1 <= w_b4 + w_b6;  r_c4 <= w_b4 - w_b6;
        r_c6 <= w_b5 + w_b7;  r_c5 <= w_b5 - w_b7;
        r_c7 <= r_b8 + w_b3;  r_c8 <= r_b8 - w_b3;
        r_c3 <= r_b0 + w_b2;  r_c0 <= r_b0 - w_b2;
      end
      if (w_ld4) begin
        r_d2 <= (C181 * (r_c4 + r_c5) + ROUND) >>> SH_OUT;
        r_d4 <= (C181 * (r_c4 - r_c5) + ROUND) >>> SH_OUT;
      end
      if (w_dc_out) begin
        for (int i = 0; i < 8; i++) r_y[i] <= r_x[0] <<< SH_DC;
        rdy <= 1'b1;
      end
      if (w_full_out) begin
        r_y[0] <= (r_c7 + r_c1) >>> SH_OUT;
        r_y[1] <= (r_c3 + r_d2) >>> SH_OUT;
        r_y[2] <= (r_c0 + r_d4) >>> SH_OUT;
        r_y[3] <= (r_c8 + r_c6) >>> SH_OUT;
        r_y[4] <= (r_c8 - r_c6) >>> SH_OUT;
        r_y[5] <= (r_c0 - r_d2) >>> SH_OUT;
        r_y[6] <= (r_c3 - r_d4) >>> SH_OUT;
        r_y[7] <= (r_c7 - r_c1) >>> SH_OUT;
        rdy    <= 1'b1;
      end
    end
  end

  assign y0 = r_y[0];
  assign y1 = r_y[1];
  assign y2 = r_y[2];
  assign y3 = r_y[3];
  assign y4 = r_y[4];
  assign y5 = r_y[5];
  assign y6 = r_y[6];
  assign y7 = r_y[7];

endmodule

// File: tb/tb_row_idct.sv
// Bench for row_idct: directed cases from the test plan plus random rows against a NanoJPEG C-style model.
module tb_row_idct;

  logic               clk;
  logic               reset;
  logic signed [31:0] x_v [8];
  logic signed [31:0] y_w [8];
  logic               rdy;

  int n_checks = 0;
  int n_errors = 0;

  row_idct dut (
    .clk(clk), .reset(reset),
    .x0(x_v[0]), .x1(x_v[1]), .x2(x_v[2]), .x3(x_v[3]),
    .x4(x_v[4]), .x5(x_v[5]), .x6(x_v[6]), .x7(x_v[7]),
    .y0(y_w[0]), .y1(y_w[1]), .y2(y_w[2]), .y3(y_w[3]),
    .y4(y_w[4]), .y5(y_w[5]), .y6(y_w[6]), .y7(y_w[7]),
    .rdy(rdy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // ---------------- reference model (NanoJPEG rowIDCT, C int semantics) ----------------
  function automatic void idct_model(input int xi[8], output int yo[8]);
    int x0, x1, x2, x3, x4, x5, x6, x7, x8;
    x0 = xi[0]; x1 = xi[4] << 11; x2 = xi[6]; x3 = xi[2];
    x4 = xi[1]; x5 = xi[7]; x6 = xi[5]; x7 = xi[3];
    if ((x1 | x2 | x3 | x4 | x5 | x6 | x7) == 0) begin
      for (int i = 0; i < 8; i++) yo[i] = x0 <<< 3;
      return;
    end
    x0 = (x0 << 11) + 128;
    x8 = 565 * (x4 + x5);
    x4 = x8 + (2841 - 565) * x4;
    x5 = x8 - (2841 + 565) * x5;
    x8 = 2408 * (x6 + x7);
    x6 = x8 - (2408 - 1609) * x6;
    x7 = x8 - (2408 + 1609) * x7;
    x8 = x0 + x1; x0 = x0 - x1;
    x1 = 1108 * (x3 + x2);
    x2 = x1 - (2676 + 1108) * x2;
    x3 = x1 + (2676 - 1108) * x3;
    x1 = x4 + x6; x4 = x4 - x6; x6 = x5 + x7; x5 = x5 - x7;
    x7 = x8 + x3; x8 = x8 - x3; x3 = x0 + x2; x0 = x0 - x2;
    x2 = (181 * (x4 + x5) + 128) >>> 8;
    x4 = (181 * (x4 - x5) + 128) >>> 8;
    yo[0] = (x7 + x1) >>> 8; yo[1] = (x3 + x2) >>> 8;
    yo[2] = (x0 + x4) >>> 8; yo[3] = (x8 + x6) >>> 8;
    yo[4] = (x8 - x6) >>> 8; yo[5] = (x0 - x2) >>> 8;
    yo[6] = (x3 - x4) >>> 8; yo[7] = (x7 - x1) >>> 8;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_y(input string tag, input int exp[8]);
    for (int i = 0; i < 8; i++) check($sformatf("%s y%0d", tag, i), y_w[i], exp[i]);
  endtask

  // ---------------- drivers ----------------
  task automatic set_x(input int xv[8]);
    for (int i = 0; i < 8; i++) x_v[i] = xv[i];
  endtask

  // Counts edges after reset release until rdy is seen; bounded so a dead DUT cannot hang.
  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!rdy && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_row(input string tag, input int xv[8], input int exp_lat, input int exp_flag);
    int lat;
    int e[8];
    set_x(xv);
    pulse_reset();
    wait_rdy(lat);
    idct_model(xv, e);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " rdy"}, {31'd0, rdy}, 32'd1);
    check({tag, " flag"}, {31'd0, dut.flag}, exp_flag);
    check_y(tag, e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int xa[8];
    int e[8];
    int spec_y[8];
    int lat;
    int exp_lat;
    int nz;

    reset = 1'b0;
    for (int i = 0; i < 8; i++) x_v[i] = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("reset rdy", {31'd0, rdy}, 32'd0);
    check("reset ctr", {29'd0, dut.ctr}, 32'd0);
    check("reset flag", {31'd0, dut.flag}, 32'd0);
    xa = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_y("reset", xa);

    // DC only
    xa = '{1, 0, 0, 0, 0, 0, 0, 0};
    run_row("dc1", xa, 2, 1);
    check("dc1 y0 const", y_w[0], 32'd8);

    // Full path with ctr stepping and spec-given outputs
    xa = '{1, 2, 3, 4, 3, 2, 1, 0};
    set_x(xa);
    pulse_reset();
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("step ctr@%0d", k), {29'd0, dut.ctr}, k);
      check($sformatf("step rdy@%0d", k), {31'd0, rdy}, 32'd0);
    end
    @(posedge clk); #1;
    check("step rdy@6", {31'd0, rdy}, 32'd1);
    check("step ctr@6", {29'd0, dut.ctr}, 32'd5);
    check("step flag", {31'd0, dut.flag}, 32'd0);
    spec_y = '{140, -26, -46, -6, -2, -6, 14, -5};
    check_y("spec", spec_y);
    idct_model(xa, e);
    check_y("spec model", e);

    // Hold after rdy: inputs wiggle, nothing moves
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 8; i++) x_v[i] = $urandom;
      @(posedge clk); #1;
      check($sformatf("hold rdy c%0d", c), {31'd0, rdy}, 32'd1);
      check($sformatf("hold y0 c%0d", c), y_w[0], spec_y[0]);
      check($sformatf("hold y7 c%0d", c), y_w[7], spec_y[7]);
    end
    check("hold ctr", {29'd0, dut.ctr}, 32'd5);

    // Zero row and negative DC
    xa = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_row("zero", xa, 2, 1);
    xa = '{-5, 0, 0, 0, 0, 0, 0, 0};
    run_row("negdc", xa, 2, 1);
    check("negdc y3 const", y_w[3], -32'sd40);

    // Reset in the middle of the full path, then rerun
    xa = '{1, 2, 3, 4, 3, 2, 1, 0};
    set_x(xa);
    pulse_reset();
    repeat (3) @(posedge clk);
    #1;
    check("mid ctr before", {29'd0, dut.ctr}, 32'd3);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid ctr", {29'd0, dut.ctr}, 32'd0);
    check("mid rdy", {31'd0, rdy}, 32'd0);
    check("mid y0", y_w[0], 32'd0);
    reset = 1'b1;
    wait_rdy(lat);
    check("rerun latency", lat, 32'd6);
    check_y("rerun", spec_y);

    // Random rows: sparse, DC-only, small and full-range values
    for (int t = 0; t < 40; t++) begin
      nz = 0;
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 3))
          0:       xa[i] = 0;
          1:       xa[i] = $urandom_range(0, 2047) - 1024;
          2:       xa[i] = $urandom_range(0, 65535) - 32768;
          default: xa[i] = $urandom;
        endcase
      end
      if ($urandom_range(0, 4) == 0)
        for (int i = 1; i < 8; i++) xa[i] = 0;
      for (int i = 1; i < 8; i++) if (xa[i] != 0) nz = 1;
      exp_lat = nz ? 6 : 2;
      run_row($sformatf("rnd%0d", t), xa, exp_lat, nz ? 0 : 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/row_idct.md
# row_idct

Single-row 8-point inverse DCT for the NanoJPEG decoder datapath, bit-exact to the integer NanoJPEG row IDCT (W1..W7 fixed-point constants, rounding, arithmetic shifts). It captures one row of eight signed dequantized coefficients and computes eight signed outputs over a few clock cycles. It then asserts `rdy` and holds the result until the next reset. The column IDCT and block-level sequencing sit outside this block.

## Interface
- Parameters: none. Constants are fixed in the shared package.
- `clk`  in  1  — single clock. All state updates on the rising edge.
- `reset`  in  1  — synchronous, active-low. `reset`=0 at a rising edge clears all state. `reset`=1 lets the block run.
- `x0`..`x7`  in  32 each, signed  — coefficient row; `x0` is DC. Sampled only at the capture edge.
- `y0`..`y7`  out  32 each, signed  — registered IDCT results.
- `rdy`  out  1  — result valid. Sticky until reset.
- Internal, probed by benches (keep these names): `ctr` (3-bit stage counter), `flag` (1 = DC-only shortcut taken).

## Operation
- Reset (`reset`=0 at an edge): `y0..y7`=0, `rdy`=0, `ctr`=0, `flag`=0, all datapath registers 0.
- Capture at the first edge with `reset`=1 and `ctr`=0, `rdy`=0:
  - latch `x0..x7`;
  - `flag` <= (`x1..x7` all zero);
  - `ctr` <= 1.
- DC shortcut (`flag`=1), next edge: all `y` <= `x0 <<< 3`; `rdy` <= 1.
- Full path (`flag`=0), in terms of the captured inputs. Constants: W1=2841, W2=2676, W3=2408, W5=1609, W6=1108, W7=565.
  - Stage 1 (`ctr`=1):
    - a0=(x0<<11)+128, a1=x4<<11;
    - p=W7·(x1+x7), q=W3·(x5+x3), r=W6·(x2+x6).
  - Stage 2 (`ctr`=2):
    - b4=p+(W1−W7)·x1, b5=p−(W1+W7)·x7;
    - b6=q−(W3−W5)·x5, b7=q−(W3+W5)·x3;
    - b8=a0+a1, b0=a0−a1;
    - b2=r−(W2+W6)·x6, b3=r+(W2−W6)·x2.
  - Stage 3 (`ctr`=3):
    - c1=b4+b6, c4=b4−b6;
    - c6=b5+b7, c5=b5−b7;
    - c7=b8+b3, c8=b8−b3;
    - c3=b0+b2, c0=b0−b2.
  - Stage 4 (`ctr`=4): d2=(181·(c4+c5)+128)>>>8, d4=(181·(c4−c5)+128)>>>8.
  - Stage 5 (`ctr`=5):
    - y0=(c7+c1)>>>8, y1=(c3+d2)>>>8, y2=(c0+d4)>>>8, y3=(c8+c6)>>>8;
    - y4=(c8−c6)>>>8, y5=(c0−d2)>>>8, y6=(c3−d4)>>>8, y7=(c7−c1)>>>8;
    - `rdy` <= 1.
- Arithmetic:
  - All intermediates are 32-bit signed, two's-complement wrap (C `int` semantics).
  - `>>>` is an arithmetic shift (floor).
  - Multiplies are by constants; truncate to 32 bits.
- Done state:
  - `rdy`=1; `y`, `ctr` and `flag` hold;
  - input changes are ignored;
  - no new transform until reset is asserted and released.

## Timing
- One transform per reset release. Inputs must be stable at the capture edge only.
- DC path: `rdy` rises 1 edge after the capture edge (2nd edge with `reset`=1).
- Full path: `rdy` rises 5 edges after the capture edge (6th edge with `reset`=1).
- `y` changes only on the edge that raises `rdy`, so `y` and `rdy` update together.
- Reset mid-computation: abort and clear at that edge. Reset wins over any stage.
- `ctr` never wraps; it stops at its final value.

## Structure
- Package `idct_pkg`: W1, W2, W3, W5, W6, W7, C181=181, ROUND=128, and shift amounts 11 and 8. The column IDCT will reuse it.
- One natural sub-module, `row_idct_rot`: computes `k·(a+b)` and the two derived products (stages 1–2). Instantiate three times: W7/W1, W3/W5, W6/W2.
- Top: FSM/counter, capture registers, butterflies, output registers.

## Test plan
- DC only, x=(1,0,0,0,0,0,0,0) -> `flag`=1; all y=8; `rdy` on 2nd edge after reset release.
- x=(1,2,3,4,3,2,1,0) -> `flag`=0; y=(140,−26,−46,−6,−2,−6,14,−5); `rdy` on 6th edge; `ctr` steps 1..5.
- Zero row -> DC path; all y=0; `rdy`=1.
- Negative DC, x=(−5,0,…,0) -> all y=−40.
- Reset asserted at `ctr`=3 -> next edge: y=0, `rdy`=0, `ctr`=0. Release and rerun the second case -> same result and latency.
- After `rdy`, change x for 10 cycles -> y and `rdy` unchanged.
